// File: rtl/rv_decode_pkg.sv
// Shared types and opcode constants for the RV32I decode queue.
package rv_decode_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // pc and imm are XLEN-wide, so they are stored beside this struct
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] f3;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [6:0] f7;
        fmt_t       fmt;
        logic       illegal;
    } decoded_entry_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational format classifier and sign-extended immediate builder.
module rv_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output fmt_t            fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [6:0]  op;
    logic [31:0] imm32;
    logic        is_i;

    assign op = instr[6:0];

    assign is_i = (op == OP_IMM) || (op == OP_LOAD)
               || (op == OP_JALR) || (op == OP_SYSTEM)
               || (op == OP_FENCE);

    always_comb begin
        fmt = FMT_NONE;
        unique case (1'b1)
            (op == OP_REG):                       fmt = FMT_R;
            is_i:                                 fmt = FMT_I;
            (op == OP_STORE):                     fmt = FMT_S;
            (op == OP_BRANCH):                    fmt = FMT_B;
            (op == OP_LUI) || (op == OP_AUIPC):   fmt = FMT_U;
            (op == OP_JAL):                       fmt = FMT_J;
            default:                              fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        imm32 = '0;
        unique case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25],
                            instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31],
                            instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // replicate bit 31 so the same expression also covers XLEN == 32
    assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

    // every legal opcode ends in 2'b11, so a bad low pair lands in NONE
    assign illegal = (fmt == FMT_NONE) || (instr[1:0] != 2'b11);

endmodule

// File: rtl/rv_decode_queue.sv
// Decodes fetched instructions and buffers the decoded fields in a FIFO
// between fetch and register-read.
module rv_decode_queue
    import rv_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_f3,
    output logic [4:0]       out_r1,
    output logic [4:0]       out_r2,
    output logic [6:0]       out_f7,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    decoded_entry_t   fields [DEPTH];
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [XLEN-1:0]  imm_q  [DEPTH];

    fmt_t             dec_fmt;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;
    decoded_entry_t   dec_entry;
    decoded_entry_t   head;

    logic             push;
    logic             pop;

    rv_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .instr   (in_instr),
        .fmt     (dec_fmt),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    always_comb begin
        dec_entry         = '0;
        dec_entry.opcode  = in_instr[6:0];
        dec_entry.rd      = in_instr[11:7];
        dec_entry.f3      = in_instr[14:12];
        dec_entry.r1      = in_instr[19:15];
        dec_entry.r2      = in_instr[24:20];
        dec_entry.f7      = in_instr[31:25];
        dec_entry.fmt     = dec_fmt;
        dec_entry.illegal = dec_illegal;
    end

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign occupancy = count;

    // input taken during a flush is dropped rather than stored
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fields[i] <= '0;
                pc_q[i]   <= '0;
                imm_q[i]  <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fields[wr_ptr] <= dec_entry;
                pc_q[wr_ptr]   <= in_pc;
                imm_q[wr_ptr]  <= dec_imm;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head        = fields[rd_ptr];
    assign out_pc      = pc_q[rd_ptr];
    assign out_imm     = imm_q[rd_ptr];
    assign out_opcode  = head.opcode;
    assign out_rd      = head.rd;
    assign out_f3      = head.f3;
    assign out_r1      = head.r1;
    assign out_r2      = head.r2;
    assign out_f7      = head.f7;
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_rv_decode_queue.sv
// Directed vector bench for rv_decode_queue (XLEN 32 and 64 instances).
module tb_rv_decode_queue;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [6:0]       out_opcode;
    logic [4:0]       out_rd;
    logic [2:0]       out_f3;
    logic [4:0]       out_r1;
    logic [4:0]       out_r2;
    logic [6:0]       out_f7;
    logic [2:0]       out_fmt;
    logic [31:0]      out_imm;
    logic             out_illegal;
    logic [CNT_W-1:0] occupancy;

    logic             w_in_valid;
    logic             w_in_ready;
    logic [63:0]      w_in_pc;
    logic             w_out_valid;
    logic [63:0]      w_out_pc;
    logic [6:0]       w_out_opcode;
    logic [4:0]       w_out_rd;
    logic [2:0]       w_out_f3;
    logic [4:0]       w_out_r1;
    logic [4:0]       w_out_r2;
    logic [6:0]       w_out_f7;
    logic [2:0]       w_out_fmt;
    logic [63:0]      w_out_imm;
    logic             w_out_illegal;
    logic [CNT_W-1:0] w_occupancy;

    int total;
    int bad;

    rv_decode_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_f3(out_f3),
        .out_r1(out_r1), .out_r2(out_r2),
        .out_f7(out_f7), .out_fmt(out_fmt),
        .out_imm(out_imm), .out_illegal(out_illegal),
        .occupancy(occupancy)
    );

    rv_decode_queue #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_instr(in_instr), .in_pc(w_in_pc),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_pc(w_out_pc), .out_opcode(w_out_opcode),
        .out_rd(w_out_rd), .out_f3(w_out_f3),
        .out_r1(w_out_r1), .out_r2(w_out_r2),
        .out_f7(w_out_f7), .out_fmt(w_out_fmt),
        .out_imm(w_out_imm), .out_illegal(w_out_illegal),
        .occupancy(w_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        illegal;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        total = 0;
        bad   = 0;

        //            instr        fmt rd  f3 r1  r2  f7     imm          ill
        vecs[0] = '{32'hFFF00093, 3'd1, 1, 0, 0, 31, 7'h7F, 32'hFFFFFFFF, 0};
        vecs[1] = '{32'h00112623, 3'd2, 12, 2, 2, 1, 7'h00, 32'h0000000C, 0};
        vecs[2] = '{32'hFE000EE3, 3'd3, 29, 0, 0, 0, 7'h7F, 32'hFFFFFFFC, 0};
        vecs[3] = '{32'h123452B7, 3'd4, 5, 5, 8, 3, 7'h09, 32'h12345000, 0};
        vecs[4] = '{32'h0000007F, 3'd6, 0, 0, 0, 0, 7'h00, 32'h00000000, 1};
        vecs[5] = '{32'h00000013, 3'd1, 0, 0, 0, 0, 7'h00, 32'h00000000, 0};
        vecs[6] = '{32'h008000EF, 3'd5, 1, 0, 0, 8, 7'h00, 32'h00000008, 0};
        vecs[7] = '{32'h002081B3, 3'd0, 3, 0, 1, 2, 7'h00, 32'h00000000, 0};
        vecs[8] = '{32'h00000012, 3'd6, 0, 0, 0, 0, 7'h00, 32'h00000000, 1};
        vecs[9] = '{32'hFFFFF017, 3'd4, 0, 7, 31, 31, 7'h7F, 32'hFFFFF000, 0};

        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_pc      = '0;
        out_ready  = 1'b0;
        w_in_valid = 1'b0;
        w_in_pc    = '0;
        step();
        step();
        rst = 1'b0;

        chk("rst_occ", 64'(occupancy), 0);
        chk("rst_oval", 64'(out_valid), 0);
        chk("rst_irdy", 64'(in_ready), 1);
        chk("rst_fmt", 64'(out_fmt), 0);
        chk("rst_imm", 64'(out_imm), 0);
        chk("rst_pc", 64'(out_pc), 0);

        // streaming: one push and one pop per cycle
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc    = 32'h100 + 32'(4*i);
            step();
            chk($sformatf("v%0d_oval", i), 64'(out_valid), 1);
            chk($sformatf("v%0d_occ", i), 64'(occupancy), 1);
            chk($sformatf("v%0d_pc", i), 64'(out_pc),
                64'(32'h100 + 32'(4*i)));
            chk($sformatf("v%0d_op", i), 64'(out_opcode),
                64'(vecs[i].instr[6:0]));
            chk($sformatf("v%0d_fmt", i), 64'(out_fmt),
                64'(vecs[i].fmt));
            chk($sformatf("v%0d_rd", i), 64'(out_rd), 64'(vecs[i].rd));
            chk($sformatf("v%0d_f3", i), 64'(out_f3), 64'(vecs[i].f3));
            chk($sformatf("v%0d_r1", i), 64'(out_r1), 64'(vecs[i].r1));
            chk($sformatf("v%0d_r2", i), 64'(out_r2), 64'(vecs[i].r2));
            chk($sformatf("v%0d_f7", i), 64'(out_f7), 64'(vecs[i].f7));
            chk($sformatf("v%0d_imm", i), 64'(out_imm),
                64'(vecs[i].imm));
            chk($sformatf("v%0d_ill", i), 64'(out_illegal),
                64'(vecs[i].illegal));
        end
        in_valid = 1'b0;
        step();
        chk("drain_occ", 64'(occupancy), 0);
        chk("drain_oval", 64'(out_valid), 0);

        // fill to full with consumer stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = vecs[0].instr;
        in_pc     = 32'h200;
        step();
        chk("f1_occ", 64'(occupancy), 1);
        chk("f1_irdy", 64'(in_ready), 1);
        in_instr = vecs[1].instr;
        in_pc    = 32'h204;
        step();
        chk("f2_occ", 64'(occupancy), 2);
        chk("f2_irdy", 64'(in_ready), 0);
        chk("f2_head", 64'(out_pc), 64'h200);
        in_instr = vecs[2].instr;
        in_pc    = 32'h208;
        step();
        chk("f3_occ", 64'(occupancy), 2);
        chk("f3_head", 64'(out_pc), 64'h200);
        chk("f3_imm", 64'(out_imm), 64'hFFFFFFFF);
        // pop while full: slot reopens only on the following cycle
        out_ready = 1'b1;
        step();
        chk("d1_occ", 64'(occupancy), 1);
        chk("d1_head", 64'(out_pc), 64'h204);
        chk("d1_irdy", 64'(in_ready), 1);
        step();
        chk("d2_occ", 64'(occupancy), 1);
        chk("d2_head", 64'(out_pc), 64'h208);
        chk("d2_fmt", 64'(out_fmt), 3);
        in_valid = 1'b0;
        step();
        chk("d3_occ", 64'(occupancy), 0);
        chk("d3_oval", 64'(out_valid), 0);

        // flush at occupancy 2 with input offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = vecs[3].instr;
        in_pc     = 32'h300;
        step();
        in_pc = 32'h304;
        step();
        chk("fl_pre_occ", 64'(occupancy), 2);
        flush = 1'b1;
        in_pc = 32'h308;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl2_occ", 64'(occupancy), 0);
        chk("fl2_oval", 64'(out_valid), 0);
        chk("fl2_irdy", 64'(in_ready), 1);

        // flush at occupancy 1 while in_ready=1: input must be dropped
        in_valid = 1'b1;
        in_pc    = 32'h400;
        step();
        chk("fl1_pre_occ", 64'(occupancy), 1);
        flush = 1'b1;
        in_pc = 32'h404;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl1_occ", 64'(occupancy), 0);
        chk("fl1_oval", 64'(out_valid), 0);
        step();
        chk("fl1_late_occ", 64'(occupancy), 0);

        // queue works again after flush
        in_valid = 1'b1;
        in_instr = vecs[6].instr;
        in_pc    = 32'h500;
        step();
        in_valid = 1'b0;
        chk("pf_occ", 64'(occupancy), 1);
        chk("pf_pc", 64'(out_pc), 64'h500);
        chk("pf_fmt", 64'(out_fmt), 5);

        // reset mid-stream with one entry held
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_oval", 64'(out_valid), 0);
        chk("mr_occ", 64'(occupancy), 0);
        chk("mr_irdy", 64'(in_ready), 1);
        chk("mr_imm", 64'(out_imm), 0);

        // 64-bit datapath: addi x1,x0,-1
        w_in_valid = 1'b1;
        in_instr   = vecs[0].instr;
        w_in_pc    = 64'h1_0000_0100;
        step();
        w_in_valid = 1'b0;
        chk("x64_oval", 64'(w_out_valid), 1);
        chk("x64_imm", w_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("x64_pc", w_out_pc, 64'h1_0000_0100);
        chk("x64_fmt", 64'(w_out_fmt), 1);
        in_instr = vecs[9].instr;
        w_in_valid = 1'b1;
        step();
        w_in_valid = 1'b0;
        chk("x64_u_imm", w_out_imm, 64'hFFFF_FFFF_FFFF_F000);
        step();
        chk("x64_occ", 64'(w_occupancy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
